multi_port_queue: RTL and testbench

- Parametrised circular FIFO for the OOO core; successor to the single-entry enqueue/dequeue queue.
- Accepts up to ENQ_WIDTH entries and releases up to DEQ_WIDTH entries per cycle.
- Provides show-ahead head entries, occupancy/free counts, an almost-full flag and a synchronous flush.
- Sits between fetch/decode and dispatch; the same block also serves as a generic ROB-style buffer.

---
 rtl/queue_pkg.sv | 23 ++
 rtl/multi_port_queue_if.sv | 42 ++++
 rtl/queue_ptr_ctrl.sv | 64 ++++++
 rtl/multi_port_queue.sv | 68 ++++++
 tb/tb_multi_port_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/queue_pkg.sv
// Shared definitions for the multi-port circular queue: default sizing,
// pointer/count width helpers and the lane data type.
package queue_pkg;

    localparam int DEF_DATA_WIDTH         = 32;
    localparam int DEF_QUEUE_DEPTH        = 64;
    localparam int DEF_ENQ_WIDTH          = 2;
    localparam int DEF_DEQ_WIDTH          = 2;
    localparam int DEF_ALMOST_FULL_THRESH = 4;

    // Pointer width carries one extra wrap bit so full and empty differ.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

endpackage

// File: rtl/multi_port_queue_if.sv
// Enqueue/dequeue bundle of the multi-port queue. The master side is the
// producer/consumer pair, the slave side is the queue itself.
interface multi_port_queue_if
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int ENQ_WIDTH   = DEF_ENQ_WIDTH,
    parameter int DEQ_WIDTH   = DEF_DEQ_WIDTH
) ();

    localparam int CW  = count_width(QUEUE_DEPTH);
    localparam int ECW = count_width(ENQ_WIDTH);
    localparam int DCW = count_width(DEQ_WIDTH);

    logic                                 flush_in;
    logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0] wdata_in;
    logic [ECW-1:0]                       enq_count_in;
    logic                                 enq_accept_out;
    logic [DCW-1:0]                       deq_count_in;
    logic                                 deq_accept_out;
    logic [DEQ_WIDTH-1:0][DATA_WIDTH-1:0] rdata_out;
    logic [DEQ_WIDTH-1:0]                 rvalid_out;
    logic [CW-1:0]                        count_out;
    logic [CW-1:0]                        free_out;
    logic                                 full_out;
    logic                                 empty_out;
    logic                                 almost_full_out;

    modport master (
        output flush_in, wdata_in, enq_count_in, deq_count_in,
        input  enq_accept_out, deq_accept_out, rdata_out, rvalid_out,
               count_out, free_out, full_out, empty_out, almost_full_out
    );

    modport slave (
        input  flush_in, wdata_in, enq_count_in, deq_count_in,
        output enq_accept_out, deq_accept_out, rdata_out, rvalid_out,
               count_out, free_out, full_out, empty_out, almost_full_out
    );

endinterface

// File: rtl/queue_ptr_ctrl.sv
// Head/tail pointer bookkeeping for the multi-port queue: accept decisions,
// occupancy and status flags. Flags derive only from the registered pointers.
module queue_ptr_ctrl
    import queue_pkg::*;
#(
    parameter int QUEUE_DEPTH        = DEF_QUEUE_DEPTH,
    parameter int ENQ_WIDTH          = DEF_ENQ_WIDTH,
    parameter int DEQ_WIDTH          = DEF_DEQ_WIDTH,
    parameter int ALMOST_FULL_THRESH = DEF_ALMOST_FULL_THRESH,
    localparam int PW  = ptr_width(QUEUE_DEPTH),
    localparam int IW  = $clog2(QUEUE_DEPTH),
    localparam int CW  = count_width(QUEUE_DEPTH),
    localparam int ECW = count_width(ENQ_WIDTH),
    localparam int DCW = count_width(DEQ_WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush_in,
    input  logic [ECW-1:0] enq_count_in,
    input  logic [DCW-1:0] deq_count_in,
    output logic           enq_accept_out,
    output logic           deq_accept_out,
    output logic [IW-1:0]  head_idx_out,
    output logic [IW-1:0]  tail_idx_out,
    output logic [CW-1:0]  count_out,
    output logic [CW-1:0]  free_out,
    output logic           full_out,
    output logic           empty_out,
    output logic           almost_full_out
);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // With a power-of-two depth the wrap-bit difference is exactly the occupancy.
    assign count_out       = CW'(tail - head);
    assign free_out        = CW'(QUEUE_DEPTH) - count_out;
    assign full_out        = (count_out == CW'(QUEUE_DEPTH));
    assign empty_out       = (count_out == '0);
    assign almost_full_out = (int'(free_out) <= ALMOST_FULL_THRESH);

    // Both sides judge against pre-edge state, so a same-cycle dequeue never frees room for enqueue.
    assign enq_accept_out  = !flush_in && (CW'(enq_count_in) <= free_out);
    assign deq_accept_out  = !flush_in && (CW'(deq_count_in) <= count_out);

    assign head_idx_out    = head[IW-1:0];
    assign tail_idx_out    = tail[IW-1:0];

    // Pointer advance; flush wins over any enqueue or dequeue in the same cycle.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush_in) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_accept_out) tail <= tail + PW'(enq_count_in);
            if (deq_accept_out) head <= head + PW'(deq_count_in);
        end
    end

endmodule

// File: rtl/multi_port_queue.sv
// Multi-port circular FIFO: up to ENQ_WIDTH writes and DEQ_WIDTH show-ahead
// reads per cycle. Holds the storage array and read muxing; pointer logic
// lives in queue_ptr_ctrl.
module multi_port_queue
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int QUEUE_DEPTH        = DEF_QUEUE_DEPTH,
    parameter int ENQ_WIDTH          = DEF_ENQ_WIDTH,
    parameter int DEQ_WIDTH          = DEF_DEQ_WIDTH,
    parameter int ALMOST_FULL_THRESH = DEF_ALMOST_FULL_THRESH
) (
    input  logic               clk,
    input  logic               rst_n,
    multi_port_queue_if.slave  q
);

    localparam int IW = $clog2(QUEUE_DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;

    data_t         mem [QUEUE_DEPTH];
    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;

    queue_ptr_ctrl #(
        .QUEUE_DEPTH        (QUEUE_DEPTH),
        .ENQ_WIDTH          (ENQ_WIDTH),
        .DEQ_WIDTH          (DEQ_WIDTH),
        .ALMOST_FULL_THRESH (ALMOST_FULL_THRESH)
    ) u_ptr_ctrl (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_in        (q.flush_in),
        .enq_count_in    (q.enq_count_in),
        .deq_count_in    (q.deq_count_in),
        .enq_accept_out  (q.enq_accept_out),
        .deq_accept_out  (q.deq_accept_out),
        .head_idx_out    (head_idx),
        .tail_idx_out    (tail_idx),
        .count_out       (q.count_out),
        .free_out        (q.free_out),
        .full_out        (q.full_out),
        .empty_out       (q.empty_out),
        .almost_full_out (q.almost_full_out)
    );

    // Write accepted lanes at consecutive slots from tail; index arithmetic wraps at the depth.
    // NOTE: storage has no reset; validity is tracked by the pointers, so stale data is never exposed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (q.enq_accept_out && (int'(q.enq_count_in) > i))
                mem[tail_idx + IW'(i)] <= q.wdata_in[i];
        end
    end

    // Show-ahead read lanes starting at head, with per-lane valid from occupancy.
    // NOTE: outputs get a default first so no path through the loop can infer a latch.
    always_comb begin
        q.rdata_out  = '0;
        q.rvalid_out = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            q.rdata_out[i]  = mem[head_idx + IW'(i)];
            q.rvalid_out[i] = (int'(q.count_out) > i);
        end
    end

endmodule

// File: tb/tb_multi_port_queue.sv
// Directed bench for multi_port_queue: a table of single-cycle vectors plus
// hand-written sequences for fill/full, wrap-around, flush and async reset.
module tb_multi_port_queue;
    import queue_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multi_port_queue_if #(
        .DATA_WIDTH (32), .QUEUE_DEPTH (64), .ENQ_WIDTH (2), .DEQ_WIDTH (2)
    ) qif ();

    multi_port_queue #(
        .DATA_WIDTH (32), .QUEUE_DEPTH (64), .ENQ_WIDTH (2), .DEQ_WIDTH (2),
        .ALMOST_FULL_THRESH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic [1:0] enq;
        lane_t      w0;
        lane_t      w1;
        logic [1:0] deq;
        logic       exp_ea;
        logic       exp_da;
        int         exp_count;
        logic [1:0] exp_rvalid;
        lane_t      exp_r0;
        lane_t      exp_r1;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic fl, input logic [1:0] ec, input lane_t w0,
                                input lane_t w1, input logic [1:0] dc, input logic ea,
                                input logic da, input int cnt, input logic [1:0] rv,
                                input lane_t r0, input lane_t r1);
        vec_t v;
        v.flush = fl; v.enq = ec; v.w0 = w0; v.w1 = w1; v.deq = dc;
        v.exp_ea = ea; v.exp_da = da; v.exp_count = cnt; v.exp_rvalid = rv;
        v.exp_r0 = r0; v.exp_r1 = r1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        qif.flush_in     = 1'b0;
        qif.enq_count_in = '0;
        qif.deq_count_in = '0;
        qif.wdata_in     = '0;
    endtask

    // Drive one request, sample accepts before the edge, return 1 time unit after it.
    task automatic apply(input logic fl, input logic [1:0] ec, input lane_t w0, input lane_t w1,
                         input logic [1:0] dc, output logic ea, output logic da);
        qif.flush_in     = fl;
        qif.enq_count_in = ec;
        qif.wdata_in[0]  = w0;
        qif.wdata_in[1]  = w1;
        qif.deq_count_in = dc;
        #1;
        ea = qif.enq_accept_out;
        da = qif.deq_accept_out;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_count(input string name, input int cnt);
        check({name, "_count"}, 64'(qif.count_out), 64'(cnt));
        check({name, "_free"},  64'(qif.free_out),  64'(64 - cnt));
        check({name, "_empty"}, 64'(qif.empty_out), 64'(cnt == 0));
        check({name, "_full"},  64'(qif.full_out),  64'(cnt == 64));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ea, da;
        checks   = 0;
        failures = 0;

        vecs[0] = mk(0, 1, 32'hcafebabe, 0,     0, 1, 1, 1, 2'b01, 32'hcafebabe, 0);
        vecs[1] = mk(0, 2, 32'h11,       32'h22, 0, 1, 1, 3, 2'b11, 32'hcafebabe, 32'h11);
        vecs[2] = mk(0, 0, 0,            0,     2, 1, 1, 1, 2'b01, 32'h22, 0);
        vecs[3] = mk(0, 0, 0,            0,     2, 1, 0, 1, 2'b01, 32'h22, 0);
        vecs[4] = mk(0, 1, 32'h33,       0,     1, 1, 1, 1, 2'b01, 32'h33, 0);
        vecs[5] = mk(0, 0, 0,            0,     1, 1, 1, 0, 2'b00, 0, 0);
        vecs[6] = mk(0, 0, 0,            0,     1, 1, 0, 0, 2'b00, 0, 0);
        vecs[7] = mk(0, 0, 0,            0,     0, 1, 1, 0, 2'b00, 0, 0);

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        #2;
        check_count("reset", 0);
        check("reset_rvalid", 64'(qif.rvalid_out), 64'd0);
        check("reset_afull",  64'(qif.almost_full_out), 64'd0);
        #10 rst_n = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].flush, vecs[i].enq, vecs[i].w0, vecs[i].w1, vecs[i].deq, ea, da);
            check($sformatf("vec%0d_enq_acc", i), 64'(ea), 64'(vecs[i].exp_ea));
            check($sformatf("vec%0d_deq_acc", i), 64'(da), 64'(vecs[i].exp_da));
            check_count($sformatf("vec%0d", i), vecs[i].exp_count);
            check($sformatf("vec%0d_rvalid", i), 64'(qif.rvalid_out), 64'(vecs[i].exp_rvalid));
            if (vecs[i].exp_rvalid[0])
                check($sformatf("vec%0d_r0", i), 64'(qif.rdata_out[0]), 64'(vecs[i].exp_r0));
            if (vecs[i].exp_rvalid[1])
                check($sformatf("vec%0d_r1", i), 64'(qif.rdata_out[1]), 64'(vecs[i].exp_r1));
        end

        // Fill 2/cycle with 0..63
        for (int k = 0; k < 32; k++) begin
            apply(0, 2, lane_t'(2*k), lane_t'(2*k+1), 0, ea, da);
            check($sformatf("fill%0d_enq_acc", k), 64'(ea), 64'd1);
            check($sformatf("fill%0d_count", k), 64'(qif.count_out), 64'(2*k+2));
            check($sformatf("fill%0d_afull", k), 64'(qif.almost_full_out), 64'((2*k+2) >= 60));
        end
        check_count("full", 64);
        check("full_r0", 64'(qif.rdata_out[0]), 64'd0);
        check("full_r1", 64'(qif.rdata_out[1]), 64'd1);
        apply(0, 1, 32'hbad, 0, 0, ea, da);
        check("over_enq_acc", 64'(ea), 64'd0);
        check_count("over", 64);

        // Full: deq 2 and enq 2 together
        apply(0, 2, 32'h100, 32'h101, 2, ea, da);
        check("fulldq_deq_acc", 64'(da), 64'd1);
        check("fulldq_enq_acc", 64'(ea), 64'd0);
        check_count("fulldq", 62);
        check("fulldq_r0", 64'(qif.rdata_out[0]), 64'd2);
        check("fulldq_r1", 64'(qif.rdata_out[1]), 64'd3);

        // Plain flush, then flush with competing requests at count 10
        apply(1, 0, 0, 0, 0, ea, da);
        check("flush0_enq_acc", 64'(ea), 64'd0);
        check("flush0_deq_acc", 64'(da), 64'd0);
        check_count("flush0", 0);
        for (int k = 0; k < 5; k++) apply(0, 2, lane_t'(200+2*k), lane_t'(201+2*k), 0, ea, da);
        check_count("pre_flush", 10);
        apply(1, 2, 32'hdead, 32'hbeef, 1, ea, da);
        check("flush1_enq_acc", 64'(ea), 64'd0);
        check("flush1_deq_acc", 64'(da), 64'd0);
        check_count("flush1", 0);
        check("flush1_rvalid", 64'(qif.rvalid_out), 64'd0);

        // Wrap: fill to 63, drain, then straddle index 63 -> 0
        for (int k = 0; k < 31; k++) apply(0, 2, lane_t'(300+2*k), lane_t'(301+2*k), 0, ea, da);
        apply(0, 1, 32'd362, 0, 0, ea, da);
        check_count("wfill", 63);
        for (int k = 0; k < 31; k++) begin
            apply(0, 0, 0, 0, 2, ea, da);
            check($sformatf("wdrain%0d_r0", k), 64'(qif.rdata_out[0]), 64'(302+2*k));
            check($sformatf("wdrain%0d_count", k), 64'(qif.count_out), 64'(61-2*k));
        end
        apply(0, 0, 0, 0, 1, ea, da);
        check_count("wdrained", 0);
        apply(0, 2, 32'ha0, 32'ha1, 0, ea, da);
        check("wrap1_r0", 64'(qif.rdata_out[0]), 64'ha0);
        check("wrap1_r1", 64'(qif.rdata_out[1]), 64'ha1);
        apply(0, 2, 32'ha2, 32'ha3, 0, ea, da);
        check_count("wrap2", 4);
        check("wrap2_r0", 64'(qif.rdata_out[0]), 64'ha0);
        apply(0, 0, 0, 0, 2, ea, da);
        check("wrap3_r0", 64'(qif.rdata_out[0]), 64'ha2);
        check("wrap3_r1", 64'(qif.rdata_out[1]), 64'ha3);
        check_count("wrap3", 2);
        apply(0, 0, 0, 0, 2, ea, da);
        check_count("wrap4", 0);

        // Over-dequeue rejected at count 1
        apply(0, 1, 32'h77, 0, 0, ea, da);
        apply(0, 0, 0, 0, 2, ea, da);
        check("overdq_deq_acc", 64'(da), 64'd0);
        check_count("overdq", 1);
        check("overdq_r0", 64'(qif.rdata_out[0]), 64'h77);
        apply(0, 0, 0, 0, 1, ea, da);
        check("lastdq_deq_acc", 64'(da), 64'd1);
        check_count("lastdq", 0);

        // Asynchronous reset mid-burst
        apply(0, 2, 32'h1, 32'h2, 0, ea, da);
        apply(0, 2, 32'h3, 32'h4, 0, ea, da);
        check_count("preburst", 4);
        qif.enq_count_in = 2'd2;
        #2 rst_n = 1'b0;
        #1;
        check_count("async_rst", 0);
        check("async_rst_rvalid", 64'(qif.rvalid_out), 64'd0);
        check("async_rst_afull",  64'(qif.almost_full_out), 64'd0);
        #2 rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        check_count("post_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
